cla_nibble_serial_adder: RTL

Nibble-serial wide adder built around a 4-bit carry-lookahead slice. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then computes one 4-bit nibble per cycle from LSB to MSB, holding the inter-nibble carry in a register. It returns the full sum, carry-out and signed overflow over a second valid/ready handshake. It sits directly around the 4-bit CLA datapath: it feeds operand nibbles and a carry-in into the slice, and it consumes the slice's sum and group carry.

---
 rtl/cla_nibble_serial_adder_if.sv | 32 +++
 rtl/cla_nibble_serial_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_serial_adder_if
// Summary  : Operand request / result response handshake bundle for the
//            nibble-serial CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_serial_adder
// Summary  : WIDTH-bit adder evaluated one nibble per cycle through a single
//            4-bit carry-lookahead slice, LSB first, with registered carry.
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cla_nibble_serial_adder_if.slave  bus
);

    localparam int c_nib   = WIDTH / 4;
    localparam int c_idx_w = (c_nib > 1) ? $clog2(c_nib) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_nib - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_idx_w-1:0] r_idx;
    logic               r_c;
    logic               r_cout;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

    logic [3:0]         w_a_nibs [c_nib];
    logic [3:0]         w_b_nibs [c_nib];
    logic [3:0]         w_a_sel;
    logic [3:0]         w_b_sel;
    logic [3:0]         w_p;
    logic [3:0]         w_g;
    logic [4:0]         w_c;
    logic [3:0]         w_s;

    // Operand nibble taps feeding the slice mux
    for (genvar gi = 0; gi < c_nib; gi++) begin : g_nib
        assign w_a_nibs[gi] = r_a[4*gi +: 4];
        assign w_b_nibs[gi] = r_b[4*gi +: 4];
    end

    assign w_a_sel  = w_a_nibs[r_idx];
    assign w_b_sel  = w_b_nibs[r_idx];
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_step   = (r_state == RUN);
    assign w_last   = w_step && (r_idx == c_last);

    // Full lookahead: every group carry is a flat function of p, g and r_c
    always_comb begin
        w_p    = w_a_sel ^ w_b_sel;
        w_g    = w_a_sel & w_b_sel;
        w_c[0] = r_c;
        w_c[1] = w_g[0] | (w_p[0] & r_c);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_c);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);
        w_s    = w_p ^ w_c[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_idx == c_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_sum  <= '0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_c    <= bus.cin;
            r_idx  <= '0;
            r_sum  <= '0;
        end else if (w_step) begin
            r_c   <= w_c[4];
            r_idx <= r_idx + c_idx_w'(1);
            for (int i = 0; i < c_nib; i++) begin
                if (r_idx == c_idx_w'(i)) begin
                    r_sum[4*i +: 4] <= w_s;
                end
            end
            // Overflow: carry into the sign bit differs from carry out of it
            if (w_last) begin
                r_cout <= w_c[4];
                r_ovf  <= w_c[3] ^ w_c[4];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire
